fd_circle_fetch_sequencer: RTL and testbench

Sequences the FAST-9 corner detector over one frame. It raster-scans every candidate centre pixel inside a border. For each centre it fetches the centre pixel plus the 16 Bresenham radius-3 circle pixels from frame memory into the detector register file. It then hands off to the comparison datapath and waits for it to finish. It sits between the frame-memory port and the FD register file/evaluator, replacing free-running fetch sequencing with a handshaked scheduler.

---
 rtl/fd_circle_fetch_sequencer_if.sv | 32 +++
 rtl/fd_circle_fetch_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_fd_circle_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fd_circle_fetch_sequencer_if.sv
// Frame-memory fetch and evaluator handshake bundle for the FAST-9 fetch sequencer.
// Optional isCorner input is present when FD_CORNER_COUNT_EN is defined.
interface fd_circle_fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [4:0]        reg_addr;
    logic              reg_we;
    logic              eval_start;
    logic              eval_done;
`ifdef FD_CORNER_COUNT_EN
    logic              is_corner;
`endif

    modport master (
        output mem_req, mem_addr, reg_addr, reg_we, eval_start,
        input  mem_ack, eval_done
`ifdef FD_CORNER_COUNT_EN
        , input is_corner
`endif
    );

    modport slave (
        input  mem_req, mem_addr, reg_addr, reg_we, eval_start,
        output mem_ack, eval_done
`ifdef FD_CORNER_COUNT_EN
        , output is_corner
`endif
    );
endinterface

// File: rtl/fd_circle_fetch_sequencer.sv
// FAST-9 frame scheduler: raster-scans centres, fetches centre + 16 circle pixels, runs evaluator.
// Define FD_CORNER_COUNT_EN to add the saturating corner counter (isCorner / cornerCount).
module fd_circle_fetch_sequencer #(
    parameter int unsigned COLUMNS = 180,
    parameter int unsigned ROWS    = 120,
    parameter int unsigned BORDER  = 3,
    parameter int unsigned ADDR_W  = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    fd_circle_fetch_sequencer_if.master bus_io,
    output logic [ADDR_W-1:0]           pix_addr_o,
    output logic                        busy_o,
    output logic                        frame_done_o
`ifdef FD_CORNER_COUNT_EN
    ,
    output logic [ADDR_W-1:0]           corner_count_o
`endif
);

    localparam int unsigned ColW = $clog2(COLUMNS);
    localparam int unsigned RowW = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] FirstPix = ADDR_W'(BORDER * COLUMNS + BORDER);
    localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(2 * BORDER + 1);
    localparam logic [ColW-1:0]   ColFirst = ColW'(BORDER);
    localparam logic [ColW-1:0]   ColLast  = ColW'(COLUMNS - 1 - BORDER);
    localparam logic [RowW-1:0]   RowFirst = RowW'(BORDER);
    localparam logic [RowW-1:0]   RowLast  = RowW'(ROWS - 1 - BORDER);

    typedef enum logic [2:0] {StIdle, StFetch, StEval, StNext, StDone} state_e;

    // Two's-complement address delta of a circle slot, relative to the centre pixel.
    function automatic logic [ADDR_W-1:0] circle_offset(input logic [4:0] idx);
        int dx;
        int dy;
        dx = 0;
        dy = 0;
        case (idx)
            5'd1:    begin dx =  0; dy = -3; end
            5'd2:    begin dx =  1; dy = -3; end
            5'd3:    begin dx =  2; dy = -2; end
            5'd4:    begin dx =  3; dy = -1; end
            5'd5:    begin dx =  3; dy =  0; end
            5'd6:    begin dx =  3; dy =  1; end
            5'd7:    begin dx =  2; dy =  2; end
            5'd8:    begin dx =  1; dy =  3; end
            5'd9:    begin dx =  0; dy =  3; end
            5'd10:   begin dx = -1; dy =  3; end
            5'd11:   begin dx = -2; dy =  2; end
            5'd12:   begin dx = -3; dy =  1; end
            5'd13:   begin dx = -3; dy =  0; end
            5'd14:   begin dx = -3; dy = -1; end
            5'd15:   begin dx = -2; dy = -2; end
            5'd16:   begin dx = -1; dy = -3; end
            default: begin dx =  0; dy =  0; end
        endcase
        return ADDR_W'(dy * int'(COLUMNS) + dx);
    endfunction

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic              eval_start_q, eval_start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              fetch_we;
    logic              eval_accept;

    assign fetch_we    = mem_req_q & bus_io.mem_ack;
    // eval_start_q marks the first EVAL cycle, during which evalDone is not yet sampled.
    assign eval_accept = (state_q == StEval) && !eval_start_q && bus_io.eval_done;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_addr_d   = pix_addr_q;
        busy_d       = busy_q;
        eval_start_d = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StFetch;
                    idx_d      = '0;
                    row_d      = RowFirst;
                    col_d      = ColFirst;
                    pix_addr_d = FirstPix;
                    busy_d     = 1'b1;
                end
            end
            StFetch: begin
                if (fetch_we) begin
                    if (idx_q == 5'd16) begin
                        state_d      = StEval;
                        eval_start_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StEval: begin
                if (eval_accept) state_d = StNext;
            end
            StNext: begin
                idx_d = '0;
                if (col_q < ColLast) begin
                    state_d    = StFetch;
                    col_d      = col_q + ColW'(1);
                    pix_addr_d = pix_addr_q + ADDR_W'(1);
                end else if (row_q < RowLast) begin
                    state_d    = StFetch;
                    col_d      = ColFirst;
                    row_d      = row_q + RowW'(1);
                    pix_addr_d = pix_addr_q + RowStep;
                end else begin
                    state_d      = StDone;
                    frame_done_d = 1'b1;
                end
            end
            StDone: begin
                state_d    = StIdle;
                busy_d     = 1'b0;
                pix_addr_d = FirstPix;
            end
            default: state_d = StIdle;
        endcase

        // Request outputs are registered from the next state so they align with FETCH cycles.
        mem_req_d  = (state_d == StFetch);
        mem_addr_d = mem_req_d ? (pix_addr_d + circle_offset(idx_d)) : '0;
        reg_addr_d = mem_req_d ? idx_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            row_q        <= RowFirst;
            col_q        <= ColFirst;
            pix_addr_q   <= FirstPix;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            reg_addr_q   <= '0;
            eval_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pix_addr_q   <= pix_addr_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            reg_addr_q   <= reg_addr_d;
            eval_start_q <= eval_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FD_CORNER_COUNT_EN
    logic [ADDR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == StIdle && start_i) begin
            count_d = '0;
        end else if (eval_accept && bus_io.is_corner && (count_q != '1)) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign corner_count_o = count_q;
`endif

    assign bus_io.mem_req    = mem_req_q;
    assign bus_io.mem_addr   = mem_addr_q;
    assign bus_io.reg_addr   = reg_addr_q;
    assign bus_io.reg_we     = fetch_we;
    assign bus_io.eval_start = eval_start_q;
    assign pix_addr_o        = pix_addr_q;
    assign busy_o            = busy_q;
    assign frame_done_o      = frame_done_q;

endmodule

// File: tb/tb_fd_circle_fetch_sequencer.sv
// Scoreboard bench: a default-size sequencer (address/handshake checks) and a small-frame
// sequencer (full-frame scan), both compared against a coordinate-level reference model.
module tb_fd_circle_fetch_sequencer;

    localparam int C = 180, R = 120, B = 3, AW = 15;
    localparam int SC = 12, SR = 10, SB = 3, SAW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_na, rst_nb, start_a, start_b;
    logic [AW-1:0]  pix_a;
    logic [SAW-1:0] pix_b;
    logic busy_a, done_a, busy_b, done_b;
`ifdef FD_CORNER_COUNT_EN
    logic [AW-1:0]  cnt_a;
    logic [SAW-1:0] cnt_b;
`endif

    fd_circle_fetch_sequencer_if #(.ADDR_W(AW))  if_a ();
    fd_circle_fetch_sequencer_if #(.ADDR_W(SAW)) if_b ();

    fd_circle_fetch_sequencer #(.COLUMNS(C), .ROWS(R), .BORDER(B), .ADDR_W(AW)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_na), .start_i(start_a), .bus_io(if_a),
        .pix_addr_o(pix_a), .busy_o(busy_a), .frame_done_o(done_a)
`ifdef FD_CORNER_COUNT_EN
        , .corner_count_o(cnt_a)
`endif
    );

    fd_circle_fetch_sequencer #(.COLUMNS(SC), .ROWS(SR), .BORDER(SB), .ADDR_W(SAW)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .start_i(start_b), .bus_io(if_b),
        .pix_addr_o(pix_b), .busy_o(busy_b), .frame_done_o(done_b)
`ifdef FD_CORNER_COUNT_EN
        , .corner_count_o(cnt_b)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=nothing", name, act);
    endtask

    // Reference model: circle geometry and raster order in plain coordinates.
    int DX [17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int DY [17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    function automatic int centre_of(input int cols, input int border, input int k);
        int inner;
        inner = cols - 2 * border;
        return (border + k / inner) * cols + border + k % inner;
    endfunction

    int exp_fetch[$];
    int exp_centre[$];

    task automatic push_candidate(input int k);
        int row, col;
        row = B + k / (C - 2 * B);
        col = B + k % (C - 2 * B);
        exp_centre.push_back(row * C + col);
        for (int i = 0; i < 17; i++) exp_fetch.push_back(((row + DY[i]) * C + col + DX[i]) * 32 + i);
    endtask

    // Default-size responder: one forced 3-cycle stall on slot 5 of the first candidate.
    bit first_cand_a = 1'b0;
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        if_a.mem_ack   = 1'b0;
        if_a.eval_done = 1'b0;
`ifdef FD_CORNER_COUNT_EN
        if_a.is_corner = 1'b0;
`endif
        forever begin
            @(posedge clk);
            #1;
            if (if_a.eval_start) begin
                first_cand_a = 1'b0;
                stall_cnt = 0;
            end
            if (first_cand_a && if_a.mem_req && if_a.reg_addr == 5'd5 && stall_cnt < 3) begin
                if_a.mem_ack = 1'b0;
                stall_cnt++;
            end else if (first_cand_a) begin
                if_a.mem_ack = 1'b1;
            end else begin
                if_a.mem_ack = ($urandom_range(0, 3) != 0);
            end
            if_a.eval_done = ($urandom_range(0, 2) == 0);
`ifdef FD_CORNER_COUNT_EN
            if_a.is_corner = 1'($urandom);
`endif
        end
    end

    // Small-frame responder: ack always, evalDone one cycle after evalStart.
    initial begin
        bit es_seen;
        es_seen = 1'b0;
        if_b.mem_ack   = 1'b1;
        if_b.eval_done = 1'b0;
`ifdef FD_CORNER_COUNT_EN
        if_b.is_corner = 1'b1;
`endif
        forever begin
            @(posedge clk);
            #1;
            if_b.eval_done = es_seen;
            es_seen = if_b.eval_start;
        end
    end

    // Default-size monitor: scoreboard pops on every fetch write and every evalStart.
    bit prev_stall = 1'b0, prev_ack16 = 1'b0;
    int prev_addr = 0, prev_reg = 0, frames_a = 0;
    always @(negedge clk) begin
        if (!rst_na) begin
            prev_stall = 1'b0;
            prev_ack16 = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_req", if_a.mem_req, 1);
                check("stall_addr", if_a.mem_addr, prev_addr);
                check("stall_reg", if_a.reg_addr, prev_reg);
            end
            if (if_a.mem_req || if_a.mem_ack)
                check("reg_we", if_a.reg_we, if_a.mem_req & if_a.mem_ack);
            if (if_a.reg_we) begin
                if (exp_fetch.size() == 0) fail_now("fetch_unexpected", if_a.mem_addr);
                else begin
                    int e;
                    e = exp_fetch.pop_front();
                    check("fetch_addr", if_a.mem_addr, e / 32);
                    check("fetch_reg", if_a.reg_addr, e % 32);
                end
            end
            if (if_a.eval_start || prev_ack16) check("eval_start_timing", if_a.eval_start, prev_ack16);
            if (if_a.eval_start) begin
                if (exp_centre.size() == 0) fail_now("centre_unexpected", pix_a);
                else check("centre", pix_a, exp_centre.pop_front());
            end
            if (done_a) frames_a++;
            prev_stall = if_a.mem_req && !if_a.mem_ack;
            prev_addr  = int'(if_a.mem_addr);
            prev_reg   = int'(if_a.reg_addr);
            prev_ack16 = if_a.reg_we && (if_a.reg_addr == 5'd16);
        end
    end

    // Small-frame monitor.
    int evals_b = 0, frames_b = 0, last_pix_b = -1;
    bit prev_done_b = 1'b0;
    localparam int SmallTotal = (SC - 2 * SB) * (SR - 2 * SB);
    always @(negedge clk) begin
        if (rst_nb) begin
            if (prev_done_b) check("small_busy_fall", busy_b, 0);
            if (if_b.eval_start) begin
                check("small_centre", pix_b, centre_of(SC, SB, evals_b));
                evals_b++;
                last_pix_b = int'(pix_b);
            end
            if (done_b) begin
                frames_b++;
                check("small_done_after_all", evals_b, SmallTotal);
                check("small_busy_at_done", busy_b, 1);
            end
            prev_done_b = done_b;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_na = 1'b0; rst_nb = 1'b0; start_a = 1'b1; start_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", if_a.mem_req, 0);
        check("rst_mem_addr", if_a.mem_addr, 0);
        check("rst_reg_addr", if_a.reg_addr, 0);
        check("rst_reg_we", if_a.reg_we, 0);
        check("rst_eval_start", if_a.eval_start, 0);
        check("rst_busy", busy_a, 0);
        check("rst_frame_done", done_a, 0);
        check("rst_pix_addr", pix_a, 543);
        start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        rst_na = 1'b1; rst_nb = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy_a, 0);
        check("idle_mem_req", if_a.mem_req, 0);

        // Scan past the row wrap (centre 716 -> 723), then reset mid-fetch.
        for (int k = 0; k < 176; k++) push_candidate(k);
        first_cand_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 30000 && exp_fetch.size() > 10; i++) @(negedge clk);
        check("reached_mid_fetch", int'(exp_fetch.size() <= 10), 1);
        check("centres_consumed", exp_centre.size(), 1);
        @(posedge clk);
        #3;
        rst_na = 1'b0;
        #1;
        check("midrst_mem_req", if_a.mem_req, 0);
        check("midrst_mem_addr", if_a.mem_addr, 0);
        check("midrst_reg_addr", if_a.reg_addr, 0);
        check("midrst_reg_we", if_a.reg_we, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_pix_addr", pix_a, 543);
        exp_fetch.delete();
        exp_centre.delete();
        @(negedge clk);
        rst_na = 1'b1;
        push_candidate(0);
        first_cand_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 2000 && exp_centre.size() > 0; i++) @(negedge clk);
        check("restart_centres", exp_centre.size(), 0);
        check("restart_fetches", exp_fetch.size(), 0);
        rst_na = 1'b0;
        check("no_frame_done_a", frames_a, 0);
`ifdef FD_CORNER_COUNT_EN
        #1;
        check("rst_corner_count", cnt_a, 0);
`endif

        // Full small frame with an ignored start in the middle.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 5000 && evals_b < 10; i++) @(negedge clk);
        check("small_busy_mid", busy_b, 1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 10000 && frames_b < 1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("small_eval_count", evals_b, SmallTotal);
        check("small_last_centre", last_pix_b, centre_of(SC, SB, SmallTotal - 1));
        check("small_frame_done_count", frames_b, 1);
        check("small_busy_end", busy_b, 0);
        check("small_pix_reload", pix_b, SB * SC + SB);
        check("small_mem_req_end", if_b.mem_req, 0);
`ifdef FD_CORNER_COUNT_EN
        check("small_corner_count", cnt_b, SmallTotal);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
